systolic_nxn_stream_top: RTL and testbench
==========================================

// Module: systolic_nxn_stream_top
// PURPOSE
//  Parametrised N x N output-stationary systolic matrix engine with streaming row/column
//  operand inputs, internal input skew, K-split accumulation across instructions and
//  requantised (shift/ReLU/saturate) output drain. Sits between the DMA stream sources and the
//  result sink. Successor to the fixed 16x16 int8 engine.
// PARAMETERS
//  N      16  array dimension (lanes per beat, PE rows = PE cols = N), N >= 2
//  IN_W   8   operand element width
//  ACC_W  32  per-PE accumulator width, >= 2*IN_W+1
//  OUT_W  8   output element width after requantisation, <= ACC_W
//  K_W    12  width of the beat-count field
// PORTS
//  CLOCK           in   1        clock; all logic on rising edge
//  reset           in   1        synchronous, active-high
//  st_instr_data   in   32       instruction: [11:0]=K beats, [12]=ACC, [13]=DRAIN, [18:14]=SHIFT, [19]=SIGNED, [20]=RELU
//  st_instr_valid  in   1        instruction valid
//  st_instr_ready  out  1        high only in IDLE
//  st_rows_data    in   N*IN_W   row operand beat; lane 0 in MSBs
//  st_rows_valid   in   1
//  st_rows_ready   out  1
//  st_cols_data    in   N*IN_W   column operand beat; lane 0 in MSBs
//  st_cols_valid   in   1
//  st_cols_ready   out  1
//  data_out_data   out  N*OUT_W  one result row per beat; lane 0 in MSBs
//  data_out_valid  out  1
//  data_out_ready  in   1
//  busy            out  1        state != IDLE
//  done            out  1        one-cycle pulse on return to IDLE
// BEHAVIOUR
//  Reset: state=IDLE, accumulators, skew lines, counters cleared; all ready/valid/busy/done=0
//   except st_instr_ready=1. Reset mid-operation abandons work; no partial output after reset.
//  FSM IDLE->READ->FLUSH->(WRITE if DRAIN)->IDLE.
//  IDLE: instr_valid latches fields; if ACC=0 accumulators cleared same edge; go READ (K=0: go FLUSH).
//  READ: beat consumed iff st_rows_valid && st_cols_valid; both readys = state==READ && both
//   valids (fused, never one without the other). Lane i delayed i beats (lane 0 zero delay);
//   skew lines and PE grid advance only on a consumed beat. After K-th beat -> FLUSH.
//  FLUSH: exactly 2N-1 cycles feeding zero beats, grid advances every cycle; then WRITE if
//   DRAIN=1, else IDLE with accumulators retained (next ACC=1 instruction continues K-split).
//  PE(r,c): acc += a_r*b_c; SIGNED=1 two's complement, else unsigned; product extended to
//   ACC_W, accumulation wraps mod 2^ACC_W. Operands pass right/down one register per advance.
//  WRITE: data_out_valid=1; beat r (0..N-1) = PE row r, lane c = quant(acc[r][c]); row index
//   advances on valid&&ready; data stable while valid && !ready. After row N-1 -> IDLE, done.
//  quant: arithmetic (SIGNED) or logical shift right by SHIFT, truncating; RELU clamps
//   negatives to 0; saturate to signed OUT_W range (unsigned range if RELU or !SIGNED).
//  Accumulators are not cleared by drain; only by ACC=0 instruction or reset.
//  Instruction latency: K + 2N-1 cycles of grid activity before first output beat (min).
// STRUCTURE
//  Package systolic_pkg: instruction field offsets/widths, state enum, quant function.
//  Sub-modules: skew_delay_line (param DEPTH, WIDTH, enable, sync reset; DEPTH=0 is a wire);
//   systolic_pe (MAC + operand forwarding registers). Grid via generate in this module.
// TESTING
//  N=4, K=4, identity rows x ramp cols, SHIFT=0, DRAIN=1 -> 4 output rows equal ramp matrix.
//  Two instrs K=2 ACC=0 DRAIN=0 then K=2 ACC=1 DRAIN=1 -> result equals single K=4 run.
//  SIGNED=1 all -128*-128, K=16, SHIFT=8, OUT_W=8 -> every lane saturates to 127; RELU with
//   -128*127 -> every lane 0.
//  Rows valid, cols withheld 5 cycles mid-READ -> no readys asserted, result unchanged vs no gap.
//  data_out_ready toggled 1/0 in WRITE -> each row emitted once, data held while stalled.
//  Assert reset in FLUSH -> next cycle IDLE, st_instr_ready=1; new ACC=1 run sees zeroed accs.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the N x N output-stationary systolic engine: instruction field
// layout, controller states and the requantisation helper.
package systolic_pkg;

   localparam int INSTR_ACC_BIT    = 12;
   localparam int INSTR_DRAIN_BIT  = 13;
   localparam int INSTR_SHIFT_LSB  = 14;
   localparam int INSTR_SHIFT_W    = 5;
   localparam int INSTR_SIGNED_BIT = 19;
   localparam int INSTR_RELU_BIT   = 20;
   localparam int QUANT_W          = 64;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_FLUSH,
      ST_WRITE
   } state_t;

   // Caller extends the accumulator to QUANT_W (sign- or zero-extended) so one helper
   // serves every ACC_W/OUT_W pairing; the result is meant to be truncated to out_w bits.
   function automatic logic [QUANT_W-1:0] quant(input logic [QUANT_W-1:0] acc_ext,
                                                input logic [INSTR_SHIFT_W-1:0] shift,
                                                input logic is_signed,
                                                input logic relu,
                                                input int out_w);
      longint v;
      longint hi;
      longint lo;
      if (is_signed)
         v = $signed(acc_ext) >>> shift;
      else
         v = $signed(acc_ext >> shift);
      if (relu || !is_signed) begin
         lo = 0;
         hi = (longint'(1) <<< out_w) - 1;
      end else begin
         hi = (longint'(1) <<< (out_w - 1)) - 1;
         lo = -hi - 1;
      end
      if (relu && v < 0)
         v = 0;
      if (v > hi)
         v = hi;
      else if (v < lo)
         v = lo;
      return $unsigned(v);
   endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Enable-gated shift register used to stagger operand lanes into the array; DEPTH=0 is a
// plain wire so lane 0 enters the grid on the same beat it is consumed.
module skew_delay_line #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out
);

   generate
      if (DEPTH == 0) begin : g_wire
         logic unused_ctrl;
         assign unused_ctrl = ^{clk, reset, enable};
         assign data_out    = data_in;
      end else begin : g_pipe
         logic [WIDTH-1:0] stage [DEPTH];

         always_ff @(posedge clk) begin
            if (reset) begin
               for (int i = 0; i < DEPTH; i++)
                  stage[i] <= '0;
            end else if (enable) begin
               stage[0] <= data_in;
               for (int i = 1; i < DEPTH; i++)
                  stage[i] <= stage[i-1];
            end
         end

         assign data_out = stage[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/systolic_pe.sv
// One processing element: multiply-accumulate on the incoming operand pair and forward
// both operands one register to the right/down neighbours on every grid advance.
module systolic_pe #(
   parameter int IN_W  = 8,
   parameter int ACC_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             clear,
   input  logic             is_signed,
   input  logic [IN_W-1:0]  a_in,
   input  logic [IN_W-1:0]  b_in,
   output logic [IN_W-1:0]  a_out,
   output logic [IN_W-1:0]  b_out,
   output logic [ACC_W-1:0] acc
);

   logic [ACC_W-1:0] a_ext;
   logic [ACC_W-1:0] b_ext;
   logic [ACC_W-1:0] product;

   // Extending both operands to ACC_W first makes the truncated product correct mod 2^ACC_W
   assign a_ext   = {{(ACC_W-IN_W){is_signed & a_in[IN_W-1]}}, a_in};
   assign b_ext   = {{(ACC_W-IN_W){is_signed & b_in[IN_W-1]}}, b_in};
   assign product = a_ext * b_ext;

   always_ff @(posedge clk) begin
      if (reset) begin
         a_out <= '0;
         b_out <= '0;
         acc   <= '0;
      end else begin
         if (enable) begin
            a_out <= a_in;
            b_out <= b_in;
         end
         if (clear)
            acc <= '0;
         else if (enable)
            acc <= acc + product;
      end
   end

endmodule

// File: rtl/systolic_nxn_stream_top.sv
// N x N output-stationary systolic engine: fused row/column operand streams, skewed into the
// grid, K-split accumulation across instructions and a requantised row-per-beat drain.
module systolic_nxn_stream_top #(
   parameter int N     = 16,
   parameter int IN_W  = 8,
   parameter int ACC_W = 32,
   parameter int OUT_W = 8,
   parameter int K_W   = 12
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        st_instr_data,
   input  logic               st_instr_valid,
   output logic               st_instr_ready,
   input  logic [N*IN_W-1:0]  st_rows_data,
   input  logic               st_rows_valid,
   output logic               st_rows_ready,
   input  logic [N*IN_W-1:0]  st_cols_data,
   input  logic               st_cols_valid,
   output logic               st_cols_ready,
   output logic [N*OUT_W-1:0] data_out_data,
   output logic               data_out_valid,
   input  logic               data_out_ready,
   output logic               busy,
   output logic               done
);

   import systolic_pkg::*;

   localparam int FW = $clog2(2*N);
   localparam int RW = $clog2(N);
   localparam logic [FW-1:0] FLUSH_LAST = FW'(2*N-2);
   localparam logic [RW-1:0] ROW_LAST   = RW'(N-1);

   state_t                   state;
   logic [K_W-1:0]           k_total;
   logic [K_W-1:0]           beat_cnt;
   logic [FW-1:0]            flush_cnt;
   logic [RW-1:0]            row_idx;
   logic                     cfg_drain;
   logic                     cfg_signed;
   logic                     cfg_relu;
   logic [INSTR_SHIFT_W-1:0] cfg_shift;

   logic beat_fire;
   logic advance;
   logic acc_clear;
   logic unused_instr;

   logic [IN_W-1:0]  row_lane [N];
   logic [IN_W-1:0]  col_lane [N];
   logic [IN_W-1:0]  row_skew [N];
   logic [IN_W-1:0]  col_skew [N];
   logic [IN_W-1:0]  a_fwd    [N][N];
   logic [IN_W-1:0]  b_fwd    [N][N];
   logic [ACC_W-1:0] acc      [N][N];
   logic [N-1:0]     unused_edge;

   assign beat_fire      = (state == ST_READ) && st_rows_valid && st_cols_valid;
   assign st_rows_ready  = beat_fire;
   assign st_cols_ready  = beat_fire;
   assign advance        = beat_fire || (state == ST_FLUSH);
   assign acc_clear      = (state == ST_IDLE) && st_instr_valid && !st_instr_data[INSTR_ACC_BIT];
   assign st_instr_ready = (state == ST_IDLE);
   assign busy           = (state != ST_IDLE);
   assign data_out_valid = (state == ST_WRITE);
   assign unused_instr   = ^st_instr_data[31:21];

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         k_total    <= '0;
         beat_cnt   <= '0;
         flush_cnt  <= '0;
         row_idx    <= '0;
         cfg_drain  <= 1'b0;
         cfg_signed <= 1'b0;
         cfg_relu   <= 1'b0;
         cfg_shift  <= '0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (st_instr_valid) begin
                  k_total    <= st_instr_data[K_W-1:0];
                  cfg_drain  <= st_instr_data[INSTR_DRAIN_BIT];
                  cfg_signed <= st_instr_data[INSTR_SIGNED_BIT];
                  cfg_relu   <= st_instr_data[INSTR_RELU_BIT];
                  cfg_shift  <= st_instr_data[INSTR_SHIFT_LSB +: INSTR_SHIFT_W];
                  beat_cnt   <= '0;
                  flush_cnt  <= '0;
                  row_idx    <= '0;
                  state      <= (st_instr_data[K_W-1:0] == '0) ? ST_FLUSH : ST_READ;
               end
            end
            ST_READ: begin
               if (beat_fire) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  if (beat_cnt == k_total - 1'b1)
                     state <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               // 2N-1 zero beats push the last operands through the far corner PE
               flush_cnt <= flush_cnt + 1'b1;
               if (flush_cnt == FLUSH_LAST) begin
                  if (cfg_drain) begin
                     state <= ST_WRITE;
                  end else begin
                     state <= ST_IDLE;
                     done  <= 1'b1;
                  end
               end
            end
            ST_WRITE: begin
               if (data_out_ready) begin
                  row_idx <= row_idx + 1'b1;
                  if (row_idx == ROW_LAST) begin
                     state <= ST_IDLE;
                     done  <= 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   genvar r, c;
   generate
      for (r = 0; r < N; r++) begin : g_lane
         assign row_lane[r] = (state == ST_READ) ? st_rows_data[(N-1-r)*IN_W +: IN_W] : '0;
         assign col_lane[r] = (state == ST_READ) ? st_cols_data[(N-1-r)*IN_W +: IN_W] : '0;
         assign unused_edge[r] = ^{a_fwd[r][N-1], b_fwd[N-1][r]};

         skew_delay_line #(.DEPTH(r), .WIDTH(IN_W)) u_row_skew (
            .clk      (clk),
            .reset    (reset),
            .enable   (advance),
            .data_in  (row_lane[r]),
            .data_out (row_skew[r])
         );

         skew_delay_line #(.DEPTH(r), .WIDTH(IN_W)) u_col_skew (
            .clk      (clk),
            .reset    (reset),
            .enable   (advance),
            .data_in  (col_lane[r]),
            .data_out (col_skew[r])
         );
      end

      for (r = 0; r < N; r++) begin : g_row
         for (c = 0; c < N; c++) begin : g_col
            logic [IN_W-1:0] a_src;
            logic [IN_W-1:0] b_src;

            if (c == 0) begin : g_a_edge
               assign a_src = row_skew[r];
            end else begin : g_a_inner
               assign a_src = a_fwd[r][c-1];
            end

            if (r == 0) begin : g_b_edge
               assign b_src = col_skew[c];
            end else begin : g_b_inner
               assign b_src = b_fwd[r-1][c];
            end

            systolic_pe #(.IN_W(IN_W), .ACC_W(ACC_W)) u_pe (
               .clk       (clk),
               .reset     (reset),
               .enable    (advance),
               .clear     (acc_clear),
               .is_signed (cfg_signed),
               .a_in      (a_src),
               .b_in      (b_src),
               .a_out     (a_fwd[r][c]),
               .b_out     (b_fwd[r][c]),
               .acc       (acc[r][c])
            );
         end
      end

      for (c = 0; c < N; c++) begin : g_out
         logic                ext_bit;
         logic [QUANT_W-1:0]  acc_ext;
         assign ext_bit = cfg_signed & acc[row_idx][c][ACC_W-1];
         assign acc_ext = {{(QUANT_W-ACC_W){ext_bit}}, acc[row_idx][c]};
         assign data_out_data[(N-1-c)*OUT_W +: OUT_W] =
            OUT_W'(quant(acc_ext, cfg_shift, cfg_signed, cfg_relu, OUT_W));
      end
   endgenerate

endmodule

// File: tb/tb_systolic_nxn_stream_top.sv
// Directed bench for the 4x4 configuration of the systolic engine with hand-computed
// result rows for identity, K-split, stall, saturation, ReLU and mid-flush reset cases.
module tb_systolic_nxn_stream_top;

   localparam int N     = 4;
   localparam int IN_W  = 8;
   localparam int ACC_W = 32;
   localparam int OUT_W = 8;
   localparam int K_W   = 12;

   logic               clk = 1'b0;
   logic               reset;
   logic [31:0]        st_instr_data;
   logic               st_instr_valid;
   logic               st_instr_ready;
   logic [N*IN_W-1:0]  st_rows_data;
   logic               st_rows_valid;
   logic               st_rows_ready;
   logic [N*IN_W-1:0]  st_cols_data;
   logic               st_cols_valid;
   logic               st_cols_ready;
   logic [N*OUT_W-1:0] data_out_data;
   logic               data_out_valid;
   logic               data_out_ready;
   logic               busy;
   logic               done;

   int compare_count  = 0;
   int mismatch_count = 0;

   logic [N*IN_W-1:0]  beat_rows [16];
   logic [N*IN_W-1:0]  beat_cols [16];
   logic [N*OUT_W-1:0] exp_rows  [N];

   systolic_nxn_stream_top #(
      .N(N), .IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .K_W(K_W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .st_instr_data  (st_instr_data),
      .st_instr_valid (st_instr_valid),
      .st_instr_ready (st_instr_ready),
      .st_rows_data   (st_rows_data),
      .st_rows_valid  (st_rows_valid),
      .st_rows_ready  (st_rows_ready),
      .st_cols_data   (st_cols_data),
      .st_cols_valid  (st_cols_valid),
      .st_cols_ready  (st_cols_ready),
      .data_out_data  (data_out_data),
      .data_out_valid (data_out_valid),
      .data_out_ready (data_out_ready),
      .busy           (busy),
      .done           (done)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      compare_count++;
      assert (observed === expected) else begin
         mismatch_count++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic issue_instr(input logic [11:0] k, input logic acc, input logic drain,
                              input logic [4:0] shift, input logic sgn, input logic relu);
      int cnt = 0;
      while (!st_instr_ready && cnt < 100) begin
         @(posedge clk); #1;
         cnt++;
      end
      checkOutput("instr_ready before issue", st_instr_ready, 1);
      st_instr_data  = {11'd0, relu, sgn, shift, drain, acc, k};
      st_instr_valid = 1'b1;
      @(posedge clk); #1;
      st_instr_valid = 1'b0;
      st_instr_data  = '0;
   endtask

   // Sends beats [first, first+count); at beat gap_at the column stream is withheld
   task automatic applyStimulus(input int first, input int count, input int gap_at,
                                input int gap_len);
      for (int b = first; b < first + count; b++) begin
         st_rows_data = beat_rows[b];
         st_cols_data = beat_cols[b];
         if (b == gap_at) begin
            st_rows_valid = 1'b1;
            st_cols_valid = 1'b0;
            for (int g = 0; g < gap_len; g++) begin
               #1;
               checkOutput("gap rows_ready", st_rows_ready, 0);
               checkOutput("gap cols_ready", st_cols_ready, 0);
               @(posedge clk); #1;
            end
         end
         st_rows_valid = 1'b1;
         st_cols_valid = 1'b1;
         #1;
         checkOutput($sformatf("beat%0d readys", b), {st_rows_ready, st_cols_ready}, 2'b11);
         @(posedge clk); #1;
      end
      st_rows_valid = 1'b0;
      st_cols_valid = 1'b0;
      st_rows_data  = '0;
      st_cols_data  = '0;
   endtask

   task automatic drain_rows(input logic toggle, input string tag);
      int cnt;
      data_out_ready = !toggle;
      for (int r = 0; r < N; r++) begin
         cnt = 0;
         while (!data_out_valid && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
         end
         checkOutput($sformatf("%s row%0d valid", tag, r), data_out_valid, 1);
         checkOutput($sformatf("%s row%0d data", tag, r), data_out_data, exp_rows[r]);
         if (toggle) begin
            @(posedge clk); #1;
            checkOutput($sformatf("%s row%0d held data", tag, r), data_out_data, exp_rows[r]);
            checkOutput($sformatf("%s row%0d held valid", tag, r), data_out_valid, 1);
            data_out_ready = 1'b1;
         end
         @(posedge clk); #1;
         if (toggle)
            data_out_ready = 1'b0;
      end
      checkOutput($sformatf("%s done pulse", tag), done, 1);
      checkOutput($sformatf("%s valid after drain", tag), data_out_valid, 0);
      checkOutput($sformatf("%s busy after drain", tag), busy, 0);
      data_out_ready = 1'b0;
      @(posedge clk); #1;
      checkOutput($sformatf("%s done single cycle", tag), done, 0);
   endtask

   task automatic wait_done(input string tag);
      int cnt = 0;
      while (!done && cnt < 100) begin
         @(posedge clk); #1;
         cnt++;
      end
      checkOutput($sformatf("%s done", tag), done, 1);
      checkOutput($sformatf("%s instr_ready", tag), st_instr_ready, 1);
   endtask

   // Identity rows times ramp columns: result rows reproduce the ramp matrix
   task automatic load_identity_ramp();
      beat_rows[0] = 32'h01000000;
      beat_rows[1] = 32'h00010000;
      beat_rows[2] = 32'h00000100;
      beat_rows[3] = 32'h00000001;
      beat_cols[0] = 32'h01020304;
      beat_cols[1] = 32'h05060708;
      beat_cols[2] = 32'h090A0B0C;
      beat_cols[3] = 32'h0D0E0F10;
      exp_rows[0]  = 32'h01020304;
      exp_rows[1]  = 32'h05060708;
      exp_rows[2]  = 32'h090A0B0C;
      exp_rows[3]  = 32'h0D0E0F10;
   endtask

   initial begin
      reset          = 1'b1;
      st_instr_data  = '0;
      st_instr_valid = 1'b0;
      st_rows_data   = '0;
      st_rows_valid  = 1'b0;
      st_cols_data   = '0;
      st_cols_valid  = 1'b0;
      data_out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      $display("[TB] reset state");
      st_rows_valid = 1'b1;
      st_cols_valid = 1'b1;
      #1;
      checkOutput("reset instr_ready", st_instr_ready, 1);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset done", done, 0);
      checkOutput("reset out_valid", data_out_valid, 0);
      checkOutput("idle rows_ready", st_rows_ready, 0);
      checkOutput("idle cols_ready", st_cols_ready, 0);
      st_rows_valid = 1'b0;
      st_cols_valid = 1'b0;
      @(posedge clk); #1;

      $display("[TB] identity x ramp, K=4");
      load_identity_ramp();
      issue_instr(12'd4, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
      checkOutput("run busy", busy, 1);
      checkOutput("run instr_ready", st_instr_ready, 0);
      applyStimulus(0, 4, -1, 0);
      drain_rows(1'b0, "ident");

      $display("[TB] K-split 2+2");
      issue_instr(12'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      applyStimulus(0, 2, -1, 0);
      wait_done("split first half");
      checkOutput("split no drain", data_out_valid, 0);
      issue_instr(12'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
      applyStimulus(2, 2, -1, 0);
      drain_rows(1'b0, "split");

      $display("[TB] column gap and output backpressure");
      issue_instr(12'd4, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
      applyStimulus(0, 4, 2, 5);
      drain_rows(1'b1, "gap");

      $display("[TB] signed saturation");
      for (int i = 0; i < 16; i++) begin
         beat_rows[i] = 32'h80808080;
         beat_cols[i] = 32'h80808080;
      end
      for (int i = 0; i < N; i++)
         exp_rows[i] = 32'h7F7F7F7F;
      issue_instr(12'd16, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
      applyStimulus(0, 16, -1, 0);
      drain_rows(1'b0, "sat");

      $display("[TB] signed relu");
      for (int i = 0; i < 16; i++)
         beat_cols[i] = 32'h7F7F7F7F;
      for (int i = 0; i < N; i++)
         exp_rows[i] = 32'h00000000;
      issue_instr(12'd16, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1);
      applyStimulus(0, 16, -1, 0);
      drain_rows(1'b0, "relu");

      $display("[TB] unsigned shift and saturation");
      beat_rows[0] = 32'hFFFFFFFF;
      beat_cols[0] = 32'h03040506;
      for (int i = 0; i < N; i++)
         exp_rows[i] = 32'hBFFFFFFF;
      issue_instr(12'd1, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0);
      applyStimulus(0, 1, -1, 0);
      drain_rows(1'b0, "ushift");

      $display("[TB] signed arithmetic shift, negative clamp");
      beat_rows[0] = 32'h80808080;
      beat_cols[0] = 32'h01020304;
      for (int i = 0; i < N; i++)
         exp_rows[i] = 32'hC0808080;
      issue_instr(12'd1, 1'b0, 1'b1, 5'd1, 1'b1, 1'b0);
      applyStimulus(0, 1, -1, 0);
      drain_rows(1'b0, "sshift");

      $display("[TB] reset during flush");
      for (int i = 0; i < 4; i++) begin
         beat_rows[i] = 32'h01010101;
         beat_cols[i] = 32'h02020202;
      end
      issue_instr(12'd4, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      applyStimulus(0, 4, -1, 0);
      @(posedge clk); #1;
      checkOutput("flush busy", busy, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checkOutput("post-reset instr_ready", st_instr_ready, 1);
      checkOutput("post-reset busy", busy, 0);
      checkOutput("post-reset out_valid", data_out_valid, 0);
      checkOutput("post-reset done", done, 0);
      load_identity_ramp();
      issue_instr(12'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
      applyStimulus(0, 4, -1, 0);
      drain_rows(1'b0, "after reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
      $finish;
   end

endmodule
